// File: rtl/posit_value_to_sum_es3.sv
// Widens an es3 posit `value` operand (9-bit scale, FBITS fraction) into the
// `value_product` accumulator format and queues it in a DEPTH-entry FIFO.
//   in1    = {sgn, scale[8:0], fraction[FBITS-1:0], inf, zero}
//   result = {sgn, scale[SW-1:0], fraction[ABITS-1:0], inf, zero}
module posit_value_to_sum_es3 #(
  parameter int DEPTH = 4,
  parameter int FBITS = 12,
  parameter int ABITS = 24,
  parameter int SW    = 12,
  localparam int IW   = FBITS + 12,
  localparam int OW   = SW + ABITS + 3,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] result,
  output logic [CW-1:0] count
);

  logic [OW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [OW-1:0] wdata;

  logic             in_sgn, in_inf, in_zero;
  logic [8:0]       in_scale;
  logic [FBITS-1:0] in_frac;

  assign in_sgn   = in1[IW-1];
  assign in_scale = in1[IW-2 -: 9];
  assign in_frac  = in1[FBITS+1:2];
  assign in_inf   = in1[1];
  assign in_zero  = in1[0];

  // Lossless widening: sign-extend scale, left-align fraction, flags verbatim.
  assign wdata = {in_sgn, {(SW-9){in_scale[8]}}, in_scale, in_frac,
                  {(ABITS-FBITS){1'b0}}, in_inf, in_zero};

  // Handshake outputs come from registered occupancy only.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign result    = mem_q[rd_q];
  assign count     = count_q;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) wr_d = (wr_q == AW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
    if (pop)  rd_d = (rd_q == AW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) mem_q[wr_q] <= wdata;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: doc/posit_value_to_sum_es3.md
# posit_value_to_sum_es3

Widening converter with elastic output buffer for the es3 posit datapath. It accepts a `value` operand (9-bit scale, FBITS fraction), expands it losslessly into the `value_product` accumulator format (full-width scale, ABITS fraction), and queues the result in a small FIFO with valid/ready handshakes on both sides. It is the inverse of the accumulator-sum-to-value narrowing step and feeds operands into the accumulator domain.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in1` holds a valid operand.
- `in_ready`  out  1  block can accept an operand this cycle.
- `in1`  in  `value`  operand fields: sgn, scale[8:0], fraction[FBITS-1:0], inf, zero.
- `out_valid`  out  1  `result` holds a valid converted operand.
- `out_ready`  in  1  downstream consumes `result` this cycle.
- `result`  out  `value_product`  converted operand (head of FIFO).
- `count`  out  $clog2(DEPTH)+1  number of occupied FIFO entries.

## Operation
- Conversion is combinational on `in1`. The result is written into the FIFO on a push.
  - `sgn`, `inf` and `zero` are copied unchanged.
  - `scale` is `in1.scale` sign-extended (bit 8 is the sign) to the full `value_product` scale width.
  - `fraction[ABITS-1:ABITS-FBITS]` = `in1.fraction`; `fraction[ABITS-FBITS-1:0]` = 0.
  - No canonicalisation: fields of zero/inf operands are carried through verbatim.
- Round-trip property: narrowing `result` back to `value` (scale[8:0], fraction top FBITS bits) returns `in1` exactly, bit for bit.
- Push = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- FIFO is a circular buffer with write pointer, read pointer and occupancy counter; both pointers wrap from DEPTH-1 to 0.
- `in_ready` = (`count` < DEPTH). It is registered-state-derived only, with no combinational path from `out_ready`.
- `out_valid` = (`count` != 0). `result` = entry at the read pointer.
- `count` next value:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on simultaneous push and pop, or on neither.
- Full (`count` = DEPTH): `in_ready` = 0. A pop in that cycle frees the slot, and `in_ready` rises the next cycle.
- Empty: `out_valid` = 0. There is no bypass, so a push into an empty FIFO appears on `result` the next cycle.
- Simultaneous push and pop at `count` = 1: the old head is consumed, the new entry becomes head next cycle, and `count` stays 1.
- `in_valid` deasserted with `in_ready` = 1: nothing is written, and the `in1` value is ignored.
- Holding `in_valid` while `in_ready` = 0 is legal. The operand is written on the first cycle `in_ready` = 1.
- `out_valid` never drops and `result` never changes while `out_valid` = 1 and `out_ready` = 0.

## Timing
- Reset (sampled at the clock edge) values:
  - `count` = 0, both pointers = 0.
  - `out_valid` = 0, `in_ready` = 1.
  - `result` = all zeros: storage is cleared, so the head reads 0.
- Reset mid-operation: all queued entries are discarded. A push or pop asserted in the reset cycle has no effect.
- Latency: 1 cycle from push to `out_valid`, when the FIFO was empty.
- Throughput: 1 operand/cycle sustained whenever `out_ready` is held high.
- Combinational paths: `in1` → FIFO write data only. The handshake outputs depend only on registered state.

## Test plan
- Reset: assert `reset` for 2 cycles with `in_valid` = 1 → `count` = 0, `out_valid` = 0, `in_ready` = 1, and nothing is queued after release.
- Widening:
  - push sgn=1, scale=9'h1F0 (−16), fraction=all ones → `result.scale` = −16 sign-extended, top FBITS fraction bits all ones, low ABITS−FBITS bits 0, sgn=1.
  - push scale=9'h0FF (+255) → `result.scale` = +255, zero-extended.
- Flag passthrough: push zero=1 with scale=5, then inf=1 with sgn=1 → both emerge in order with fields unchanged. The round-trip narrowing equals the input.
- Fill/backpressure, with DEPTH=4 and `out_ready` = 0:
  - push 5 distinct operands with `in_valid` held → `in_ready` falls after 4 pushes and `count` = 4.
  - release `out_ready` → operands 1–5 emerge in order, and the 5th is accepted one cycle after the first pop.
- Streaming and wrap: 20 random operands with `in_valid` and `out_ready` both random ~50% → FIFO order preserved across pointer wrap, `count` matches the model every cycle, and no loss or duplication.
- Simultaneous push/pop at `count` = 1 and at `count` = DEPTH−1 → `count` unchanged and order correct. A mid-stream reset with 3 entries queued → queue empty and post-reset pushes output first.
